// File: rtl/mux2_rr_stream_arb_if.sv
// Stream bundle for the 2:1 round-robin arbiter: two source streams in,
// one tagged output stream plus occupancy.
interface mux2_rr_stream_arb_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] y_data;
  logic             y_src;
  logic             y_valid;
  logic             y_ready;
  logic [1:0]       count;

  // Arbiter side
  modport slave (
    input  a_data, a_valid, b_data, b_valid, y_ready,
    output a_ready, b_ready, y_data, y_src, y_valid, count
  );

  // Environment side (sources and consumer)
  modport master (
    output a_data, a_valid, b_data, b_valid, y_ready,
    input  a_ready, b_ready, y_data, y_src, y_valid, count
  );

endinterface

// File: rtl/mux2_rr_stream_arb.sv
// Round-robin arbiter between two valid/ready streams feeding a 2-entry
// in-order queue. The head word is presented with a source tag that can
// drive a downstream mux select.
module mux2_rr_stream_arb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  mux2_rr_stream_arb_if.slave    s
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             prio_b_q, prio_b_d;   // 1: B wins the next contested cycle
  logic [WIDTH-1:0] d0_q, d0_d;           // head entry
  logic             s0_q, s0_d;
  logic [WIDTH-1:0] d1_q, d1_d;           // second entry
  logic             s1_q, s1_d;

  logic             slot_free;
  logic             grant_a;
  logic             grant_b;
  logic             enq;
  logic             deq;
  logic [WIDTH-1:0] enq_data;
  logic             enq_src;

  // Grant decision; readies are forced low during reset and when full
  always_comb begin
    slot_free = (state_q != FULL);
    grant_a   = !rst && slot_free && s.a_valid && (!s.b_valid || !prio_b_q);
    grant_b   = !rst && slot_free && s.b_valid && (!s.a_valid ||  prio_b_q);
    enq       = grant_a || grant_b;
    enq_data  = grant_b ? s.b_data : s.a_data;
    enq_src   = grant_b;
    deq       = (state_q != EMPTY) && s.y_ready;
  end

  // Next state of occupancy, queue entries and priority pointer
  always_comb begin
    state_d  = state_q;
    prio_b_d = prio_b_q;
    d0_d     = d0_q;
    s0_d     = s0_q;
    d1_d     = d1_q;
    s1_d     = s1_q;

    // Pointer moves only on an accepted transfer, to the other source
    if (enq) begin
      prio_b_d = grant_a;
    end

    case (state_q)
      EMPTY: begin
        if (enq) begin
          d0_d    = enq_data;
          s0_d    = enq_src;
          state_d = ONE;
        end
      end
      ONE: begin
        if (enq && deq) begin
          d0_d = enq_data;
          s0_d = enq_src;
        end else if (enq) begin
          d1_d    = enq_data;
          s1_d    = enq_src;
          state_d = FULL;
        end else if (deq) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // No enqueue possible here, so only the shift on dequeue
        if (deq) begin
          d0_d    = d1_q;
          s0_d    = s1_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State registers; reset flushes the queue and gives A first priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      prio_b_q <= 1'b0;
      d0_q     <= '0;
      s0_q     <= 1'b0;
      d1_q     <= '0;
      s1_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_b_q <= prio_b_d;
      d0_q     <= d0_d;
      s0_q     <= s0_d;
      d1_q     <= d1_d;
      s1_q     <= s1_d;
    end
  end

  // Output drive: head entry straight from its registers
  assign s.a_ready = grant_a;
  assign s.b_ready = grant_b;
  assign s.y_data  = d0_q;
  assign s.y_src   = s0_q;
  assign s.y_valid = (state_q != EMPTY);
  assign s.count   = 2'(state_q);

endmodule

// File: tb/tb_mux2_rr_stream_arb.sv
// Directed bench for mux2_rr_stream_arb: reset, single source, contention,
// backpressure, simultaneous enqueue/dequeue, pointer hold, reset mid-stream.
module tb_mux2_rr_stream_arb;

  localparam int unsigned WIDTH = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  mux2_rr_stream_arb_if #(.WIDTH(WIDTH)) ifc ();

  mux2_rr_stream_arb #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .s   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_y(input string tag, input logic v, input logic [3:0] d, input logic src,
                         input logic [1:0] cnt);
    check({tag, ".y_valid"}, 32'(ifc.y_valid), 32'(v));
    if (v) begin
      check({tag, ".y_data"}, 32'(ifc.y_data), 32'(d));
      check({tag, ".y_src"},  32'(ifc.y_src),  32'(src));
    end
    check({tag, ".count"}, 32'(ifc.count), 32'(cnt));
  endtask

  task automatic check_rdy(input string tag, input logic ar, input logic br);
    check({tag, ".a_ready"}, 32'(ifc.a_ready), 32'(ar));
    check({tag, ".b_ready"}, 32'(ifc.b_ready), 32'(br));
  endtask

  // Apply inputs for the current cycle and let combinational paths settle
  task automatic drive(input logic av, input logic [3:0] ad, input logic bv, input logic [3:0] bd,
                       input logic yr);
    ifc.a_valid = av;
    ifc.a_data  = ad;
    ifc.b_valid = bv;
    ifc.b_data  = bd;
    ifc.y_ready = yr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(1'b1, 4'h3, 1'b1, 4'h9, 1'b1);

    // Reset state, with both sources valid
    tick();
    check("rst.y_data", 32'(ifc.y_data), 32'h0);
    check("rst.y_src",  32'(ifc.y_src),  32'h0);
    check_y("rst", 1'b0, 4'h0, 1'b0, 2'd0);
    check_rdy("rst", 1'b0, 1'b0);
    rst = 1'b0;

    // Single source A: 3,5,7
    drive(1'b1, 4'h3, 1'b0, 4'h0, 1'b1);
    check_rdy("single.c0", 1'b1, 1'b0);
    check_y("single.c0", 1'b0, 4'h0, 1'b0, 2'd0);
    tick(); drive(1'b1, 4'h5, 1'b0, 4'h0, 1'b1);
    check_y("single.c1", 1'b1, 4'h3, 1'b0, 2'd1);
    check_rdy("single.c1", 1'b1, 1'b0);
    tick(); drive(1'b1, 4'h7, 1'b0, 4'h0, 1'b1);
    check_y("single.c2", 1'b1, 4'h5, 1'b0, 2'd1);
    tick(); drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    check_y("single.c3", 1'b1, 4'h7, 1'b0, 2'd1);
    tick();
    check_y("single.c4", 1'b0, 4'h0, 1'b0, 2'd0);

    // Re-reset so contention starts from the A-first pointer
    rst = 1'b1; #1; rst = 1'b0;

    // Contention: a=1, b=9, both valid, consumer ready
    drive(1'b1, 4'h1, 1'b1, 4'h9, 1'b1);
    check_rdy("cont.c0", 1'b1, 1'b0);
    tick();
    check_y("cont.c1", 1'b1, 4'h1, 1'b0, 2'd1);
    check_rdy("cont.c1", 1'b0, 1'b1);
    tick();
    check_y("cont.c2", 1'b1, 4'h9, 1'b1, 2'd1);
    check_rdy("cont.c2", 1'b1, 1'b0);
    tick();
    check_y("cont.c3", 1'b1, 4'h1, 1'b0, 2'd1);
    check_rdy("cont.c3", 1'b0, 1'b1);
    tick(); drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    check_y("cont.c4", 1'b1, 4'h9, 1'b1, 2'd1);
    tick();
    check_y("cont.c5", 1'b0, 4'h0, 1'b0, 2'd0);

    // Backpressure: last grant was B, so A wins first; fill to 2
    drive(1'b1, 4'h2, 1'b1, 4'hC, 1'b0);
    check_rdy("bp.c0", 1'b1, 1'b0);
    tick();
    check_y("bp.c1", 1'b1, 4'h2, 1'b0, 2'd1);
    check_rdy("bp.c1", 1'b0, 1'b1);
    tick();
    check_y("bp.c2", 1'b1, 4'h2, 1'b0, 2'd2);
    check_rdy("bp.c2", 1'b0, 1'b0);
    tick(); drive(1'b1, 4'h2, 1'b1, 4'hC, 1'b1);
    check_y("bp.c3", 1'b1, 4'h2, 1'b0, 2'd2);
    check_rdy("bp.c3_full_ready", 1'b0, 1'b0);
    tick(); drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    check_y("bp.c4", 1'b1, 4'hC, 1'b1, 2'd1);
    tick();
    check_y("bp.c5", 1'b0, 4'h0, 1'b0, 2'd0);

    // Simultaneous enqueue/dequeue at count=1
    drive(1'b1, 4'h4, 1'b0, 4'h0, 1'b0);
    tick(); drive(1'b0, 4'h0, 1'b1, 4'h6, 1'b1);
    check_y("sim.c1", 1'b1, 4'h4, 1'b0, 2'd1);
    check_rdy("sim.c1", 1'b0, 1'b1);
    tick(); drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    check_y("sim.c2", 1'b1, 4'h6, 1'b1, 2'd1);
    tick();
    check_y("sim.c3", 1'b0, 4'h0, 1'b0, 2'd0);

    // Pointer hold: grant B, three idle cycles, then contest -> A
    drive(1'b0, 4'h0, 1'b1, 4'hA, 1'b1);
    check_rdy("hold.grant_b", 1'b0, 1'b1);
    tick(); drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    check_y("hold.c1", 1'b1, 4'hA, 1'b1, 2'd1);
    tick(); tick(); tick();
    drive(1'b1, 4'h5, 1'b1, 4'hD, 1'b1);
    check_rdy("hold.contest", 1'b1, 1'b0);
    tick();
    check_y("hold.after", 1'b1, 4'h5, 1'b0, 2'd1);

    // Reset mid-stream at count=2 with pointer favouring B
    drive(1'b1, 4'h8, 1'b0, 4'h0, 1'b0);
    check_rdy("rstm.fill", 1'b1, 1'b0);
    tick(); drive(1'b1, 4'h8, 1'b1, 4'hE, 1'b0);
    check_y("rstm.full", 1'b1, 4'h5, 1'b0, 2'd2);
    rst = 1'b1; #1;
    check_y("rstm.in_rst", 1'b0, 4'h0, 1'b0, 2'd0);
    check_rdy("rstm.in_rst", 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b1, 4'h8, 1'b1, 4'hE, 1'b1);
    check_rdy("rstm.first_contest", 1'b1, 1'b0);
    tick(); drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    check_y("rstm.after", 1'b1, 4'h8, 1'b0, 2'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
